// File: rtl/driver_cntrl_pkg.sv
// Shared register offsets, control/status bit positions and program FSM states.
// Latency: n/a (declarations only). Backpressure: n/a.
package driver_cntrl_pkg;

  localparam logic [31:0] REG_ADDR     = 32'h0000_0000;
  localparam logic [31:0] REG_CTRL     = 32'h0000_0004;
  localparam logic [31:0] REG_IRQ_EN   = 32'h0000_0008;
  localparam logic [31:0] REG_STATUS   = 32'h0000_0100;
  localparam logic [31:0] REG_ADDR_CYC = 32'h0000_0104;
  localparam logic [31:0] REG_ADDR_LVL = 32'h0000_0108;
  localparam logic [31:0] REG_VCTR_CYC = 32'h0000_010C;
  localparam logic [31:0] REG_VCTR_LVL = 32'h0000_0110;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_END      = 1;
  localparam int CTRL_ABORT    = 2;
  localparam int CTRL_FRZ_ADDR = 3;
  localparam int CTRL_FRZ_VCTR = 4;
  localparam int CTRL_CONSEC   = 7;
  localparam int CTRL_CNT_LSB  = 8;

  localparam int ST_ACTIVE  = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_DROP    = 2;
  localparam int ST_DONE    = 3;
  localparam int ST_REM_LSB = 8;

  typedef enum logic {
    PROG_IDLE   = 1'b0,
    PROG_ACTIVE = 1'b1
  } prog_state_e;

  typedef struct packed {
    logic [7:0] consec_count;
    logic       send_consec;
    logic       freeze_vctr;
    logic       freeze_addr;
  } ctrl_t;

  // A zero consec_count still sends the addressed word itself.
  function automatic logic [7:0] burst_len(input logic send_consec, input logic [7:0] cnt);
    if (!send_consec || cnt == 8'd0) return 8'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/driver_cntrl_burst_if.sv
// Host slave register bus: one-cycle rd/wr strobes, registered read data with valid.
// Latency: read data 1 cycle after slave_rd. Backpressure: none, every access completes.
interface driver_cntrl_burst_if;
  logic [31:0] slave_addr;
  logic        slave_rd;
  logic        slave_wr;
  logic [31:0] slave_data_in;
  logic [31:0] slave_data_out;
  logic        slave_rd_valid;

  modport master (
    output slave_addr, slave_rd, slave_wr, slave_data_in,
    input  slave_data_out, slave_rd_valid
  );

  modport slave (
    input  slave_addr, slave_rd, slave_wr, slave_data_in,
    output slave_data_out, slave_rd_valid
  );
endinterface

// File: rtl/driver_addr_burst.sv
// Address burst engine: loads base/count, pushes base + n*STRIDE one word per cycle.
// Latency: first word 1 cycle after start. Backpressure: stalls on full or freeze, abort flushes.
module driver_addr_burst #(
  parameter logic [31:0] STRIDE = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base,
  input  logic [7:0]  count,
  input  logic        full,
  input  logic        freeze,
  input  logic        abort,
  output logic        wr,
  output logic [31:0] din,
  output logic        busy,
  output logic [7:0]  remaining
);

  logic [31:0] next_addr_q;
  logic [7:0]  rem_q;

  assign busy      = (rem_q != 8'd0);
  // Abort suppresses the push in its own cycle so no word escapes after the command.
  assign wr        = busy && !full && !freeze && !abort;
  assign din       = next_addr_q;
  assign remaining = rem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_addr_q <= '0;
      rem_q       <= '0;
    end else if (abort) begin
      rem_q <= '0;
    end else if (start && !busy) begin
      next_addr_q <= base;
      rem_q       <= count;
    end else if (wr) begin
      next_addr_q <= next_addr_q + STRIDE;
      rem_q       <= rem_q - 8'd1;
    end
  end

endmodule

// File: rtl/driver_cntrl_burst.sv
// Driver control/status: register map, addr-FIFO burst feeder, run/end/abort FSM, monitor readback; DRV_CNTRL_IRQ_EN adds irq.
// Latency: read data, command pulses and first burst word all 1 cycle after the access.
// Backpressure: burst stalls on addr_fifo_full/freeze without loss; pushes while busy are dropped.
module driver_cntrl_burst
  import driver_cntrl_pkg::*;
#(
  parameter int          NUM_MON       = 16,
  parameter int          CNT_W         = 16,
  parameter logic [31:0] ADDR_STRIDE   = 32'd4,
  parameter logic [31:0] ADDR_MON_BASE = 32'h0001_1000,
  parameter logic [31:0] VCTR_MON_BASE = 32'h0001_2000
) (
  input  logic                     clk,
  input  logic                     reset,
  driver_cntrl_burst_if.slave      bus,
  input  logic [CNT_W-1:0]         addr_cycle_cnt,
  input  logic [CNT_W-1:0]         vctr_cycle_cnt,
  input  logic [CNT_W-1:0]         words_in_addr_fifo,
  input  logic [CNT_W-1:0]         words_in_vctr_fifo,
  input  logic [NUM_MON*CNT_W-1:0] addr_mon_cnts,
  input  logic [NUM_MON*CNT_W-1:0] vctr_mon_cnts,
  input  logic                     addr_fifo_full,
  output logic [31:0]              addr_fifo_din,
  output logic                     addr_fifo_wr,
  output logic                     run_program,
  output logic                     end_program,
  output logic                     abort_program,
  output logic                     active_program,
  output logic                     freeze_addr_fifo,
  output logic                     freeze_vector_fifo,
  output logic                     irq
);

  ctrl_t       ctrl_q;
  logic        run_q, end_q, abort_q;
  prog_state_e state_q, state_d;
  logic        drop_err_q, prog_done_q;
  logic [31:0] last_push_q;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;

  logic        burst_wr, burst_busy;
  logic [31:0] burst_din;
  logic [7:0]  burst_rem, burst_k;
  logic [31:0] wdat, rd_mux, ctrl_rd, status, irq_en_rd, addr_off, vctr_off;
  logic        wr_push, wr_ctrl, wr_status;

  assign wdat      = bus.slave_data_in;
  assign wr_push   = bus.slave_wr && (bus.slave_addr == REG_ADDR);
  assign wr_ctrl   = bus.slave_wr && (bus.slave_addr == REG_CTRL);
  assign wr_status = bus.slave_wr && (bus.slave_addr == REG_STATUS);
  assign burst_k   = burst_len(ctrl_q.send_consec, ctrl_q.consec_count);

  driver_addr_burst #(.STRIDE(ADDR_STRIDE)) u_burst (
    .clk       (clk),
    .reset     (reset),
    .start     (wr_push),
    .base      (wdat),
    .count     (burst_k),
    .full      (addr_fifo_full),
    .freeze    (ctrl_q.freeze_addr),
    .abort     (abort_q),
    .wr        (burst_wr),
    .din       (burst_din),
    .busy      (burst_busy),
    .remaining (burst_rem)
  );

  // Command bits decode to at most one pulse: abort beats end beats run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      run_q   <= 1'b0;
      end_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      run_q   <= wr_ctrl && wdat[CTRL_RUN] && !wdat[CTRL_END] && !wdat[CTRL_ABORT];
      end_q   <= wr_ctrl && wdat[CTRL_END] && !wdat[CTRL_ABORT];
      abort_q <= wr_ctrl && wdat[CTRL_ABORT];
      if (wr_ctrl) begin
        ctrl_q.freeze_addr  <= wdat[CTRL_FRZ_ADDR];
        ctrl_q.freeze_vctr  <= wdat[CTRL_FRZ_VCTR];
        ctrl_q.send_consec  <= wdat[CTRL_CONSEC];
        ctrl_q.consec_count <= wdat[CTRL_CNT_LSB +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= PROG_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PROG_IDLE:   if (run_q)            state_d = PROG_ACTIVE;
      PROG_ACTIVE: if (end_q || abort_q) state_d = PROG_IDLE;
      default:                           state_d = PROG_IDLE;
    endcase
  end

  // Sticky flags: a new event wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_err_q  <= 1'b0;
      prog_done_q <= 1'b0;
      last_push_q <= '0;
    end else begin
      drop_err_q  <= (wr_push && burst_busy) || (drop_err_q && !(wr_status && wdat[ST_DROP]));
      prog_done_q <= end_q || abort_q || (prog_done_q && !(wr_status && wdat[ST_DONE]));
      if (burst_wr) last_push_q <= burst_din;
    end
  end

`ifdef DRV_CNTRL_IRQ_EN
  logic       wr_irq_en;
  logic [1:0] irq_en_q;
  logic       irq_q;

  assign wr_irq_en = bus.slave_wr && (bus.slave_addr == REG_IRQ_EN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_irq_en) irq_en_q <= wdat[1:0];
      irq_q <= |({prog_done_q, drop_err_q} & irq_en_q);
    end
  end

  assign irq       = irq_q;
  assign irq_en_rd = {30'b0, irq_en_q};
`else
  assign irq       = 1'b0;
  assign irq_en_rd = '0;
`endif

  always_comb begin
    ctrl_rd                       = '0;
    ctrl_rd[CTRL_FRZ_ADDR]        = ctrl_q.freeze_addr;
    ctrl_rd[CTRL_FRZ_VCTR]        = ctrl_q.freeze_vctr;
    ctrl_rd[CTRL_CONSEC]          = ctrl_q.send_consec;
    ctrl_rd[CTRL_CNT_LSB +: 8]    = ctrl_q.consec_count;
    status                        = '0;
    status[ST_ACTIVE]             = (state_q == PROG_ACTIVE);
    status[ST_BUSY]               = burst_busy;
    status[ST_DROP]               = drop_err_q;
    status[ST_DONE]               = prog_done_q;
    status[ST_REM_LSB +: 8]       = burst_rem;
  end

  assign addr_off = bus.slave_addr - ADDR_MON_BASE;
  assign vctr_off = bus.slave_addr - VCTR_MON_BASE;

  always_comb begin
    rd_mux = '0;
    case (bus.slave_addr)
      REG_ADDR:     rd_mux = last_push_q;
      REG_CTRL:     rd_mux = ctrl_rd;
      REG_IRQ_EN:   rd_mux = irq_en_rd;
      REG_STATUS:   rd_mux = status;
      REG_ADDR_CYC: rd_mux = 32'(addr_cycle_cnt);
      REG_ADDR_LVL: rd_mux = 32'(words_in_addr_fifo);
      REG_VCTR_CYC: rd_mux = 32'(vctr_cycle_cnt);
      REG_VCTR_LVL: rd_mux = 32'(words_in_vctr_fifo);
      default:      rd_mux = '0;
    endcase
    for (int i = 0; i < NUM_MON; i++) begin
      if (addr_off == 32'(4 * i)) rd_mux = 32'(addr_mon_cnts[i*CNT_W +: CNT_W]);
      if (vctr_off == 32'(4 * i)) rd_mux = 32'(vctr_mon_cnts[i*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.slave_rd;
      rd_data_q  <= bus.slave_rd ? rd_mux : 32'h0;
    end
  end

  assign bus.slave_data_out = rd_data_q;
  assign bus.slave_rd_valid = rd_valid_q;

  assign addr_fifo_wr       = burst_wr;
  assign addr_fifo_din      = burst_din;
  assign run_program        = run_q;
  assign end_program        = end_q;
  assign abort_program      = abort_q;
  assign active_program     = (state_q == PROG_ACTIVE);
  assign freeze_addr_fifo   = ctrl_q.freeze_addr;
  assign freeze_vector_fifo = ctrl_q.freeze_vctr;

endmodule

// File: tb/tb_driver_cntrl_burst.sv
// Bench for driver_cntrl_burst: directed register/burst/FSM sequences, scoreboard queues for pushes and reads.
// Build with or without DRV_CNTRL_IRQ_EN; irq expectations follow the build.
`timescale 1ns/1ps
module tb_driver_cntrl_burst;

  localparam int          NUM_MON = 16;
  localparam int          CNT_W   = 16;
  localparam logic [31:0] AMB     = 32'h0001_1000;
  localparam logic [31:0] VMB     = 32'h0001_2000;
`ifdef DRV_CNTRL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [CNT_W-1:0]         addr_cycle_cnt, vctr_cycle_cnt, words_in_addr_fifo, words_in_vctr_fifo;
  logic [NUM_MON*CNT_W-1:0] addr_mon_cnts, vctr_mon_cnts;
  logic                     addr_fifo_full;
  logic [31:0]              addr_fifo_din;
  logic addr_fifo_wr, run_program, end_program, abort_program, active_program;
  logic freeze_addr_fifo, freeze_vector_fifo, irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] push_q[$];
  logic [31:0] rd_q[$];

  always #5 clk = ~clk;

  driver_cntrl_burst_if bus();

  driver_cntrl_burst dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .addr_cycle_cnt     (addr_cycle_cnt),
    .vctr_cycle_cnt     (vctr_cycle_cnt),
    .words_in_addr_fifo (words_in_addr_fifo),
    .words_in_vctr_fifo (words_in_vctr_fifo),
    .addr_mon_cnts      (addr_mon_cnts),
    .vctr_mon_cnts      (vctr_mon_cnts),
    .addr_fifo_full     (addr_fifo_full),
    .addr_fifo_din      (addr_fifo_din),
    .addr_fifo_wr       (addr_fifo_wr),
    .run_program        (run_program),
    .end_program        (end_program),
    .abort_program      (abort_program),
    .active_program     (active_program),
    .freeze_addr_fifo   (freeze_addr_fifo),
    .freeze_vector_fifo (freeze_vector_fifo),
    .irq                (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_empty_pop(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h, expected nothing", name, act);
  endtask

  // Monitor: pops expected pushes and read data as the DUT presents them.
  always @(negedge clk) begin
    if (reset) begin
      if (addr_fifo_wr) begin
        check("no_wr_while_full", 32'(addr_fifo_full), 32'h0);
        if (push_q.size() == 0) check_empty_pop("unexpected_push", addr_fifo_din);
        else check("push_din", addr_fifo_din, push_q.pop_front());
      end
      if (bus.slave_rd_valid) begin
        if (rd_q.size() == 0) check_empty_pop("unexpected_rd_valid", bus.slave_data_out);
        else check("rd_data", bus.slave_data_out, rd_q.pop_front());
      end
    end
  end

  // All tasks start and end 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    bus.slave_addr    = a;
    bus.slave_data_in = d;
    bus.slave_wr      = 1'b1;
    @(posedge clk);
    #1;
    bus.slave_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus.slave_addr = a;
    bus.slave_rd   = 1'b1;
    @(posedge clk);
    #1;
    bus.slave_rd = 1'b0;
  endtask

  function automatic logic [8:0] out_vec();
    return {addr_fifo_wr, run_program, end_program, abort_program, active_program,
            freeze_addr_fifo, freeze_vector_fifo, irq, bus.slave_rd_valid};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.slave_addr     = '0;
    bus.slave_rd       = 1'b0;
    bus.slave_wr       = 1'b0;
    bus.slave_data_in  = '0;
    addr_fifo_full     = 1'b0;
    addr_cycle_cnt     = 16'h1234;
    words_in_addr_fifo = 16'h0055;
    vctr_cycle_cnt     = 16'h5678;
    words_in_vctr_fifo = 16'h0066;
    for (int i = 0; i < NUM_MON; i++) begin
      addr_mon_cnts[i*CNT_W +: CNT_W] = 16'hA000 + 16'(i);
      vctr_mon_cnts[i*CNT_W +: CNT_W] = 16'hB000 + 16'(i);
    end

    // Reset state
    #2;
    check("reset_outputs", 32'(out_vec()), 32'h0);
    check("reset_din", addr_fifo_din, 32'h0);
    check("reset_rd_data", bus.slave_data_out, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    rd_reg(32'h100, 32'h0);
    rd_reg(32'h004, 32'h0);

    // 1: single push, one cycle after the write
    push_q.push_back(32'h1000);
    wr_reg(32'h000, 32'h1000);
    check("t1_wr_next_cycle", 32'(addr_fifo_wr), 32'h1);
    idle(1);
    check("t1_single_word", 32'(addr_fifo_wr), 32'h0);
    rd_reg(32'h000, 32'h1000);

    // 2: four-word consecutive burst
    wr_reg(32'h004, 32'h0000_0480);
    rd_reg(32'h004, 32'h0000_0480);
    push_q.push_back(32'h100); push_q.push_back(32'h104);
    push_q.push_back(32'h108); push_q.push_back(32'h10C);
    wr_reg(32'h000, 32'h100);
    for (int k = 0; k < 4; k++) begin
      check("t2_wr_consecutive", 32'(addr_fifo_wr), 32'h1);
      idle(1);
    end
    check("t2_wr_done", 32'(addr_fifo_wr), 32'h0);
    rd_reg(32'h100, 32'h0);

    // 3: three words with full stall, push while busy is dropped
    wr_reg(32'h004, 32'h0000_0380);
    push_q.push_back(32'h2000); push_q.push_back(32'h2004); push_q.push_back(32'h2008);
    wr_reg(32'h000, 32'h2000);
    idle(1);
    addr_fifo_full = 1'b1;
    #1;
    check("t3_no_wr_when_full", 32'(addr_fifo_wr), 32'h0);
    wr_reg(32'h000, 32'h5000);
    idle(1);
    addr_fifo_full = 1'b0;
    idle(4);
    rd_reg(32'h100, 32'h4);
    wr_reg(32'h100, 32'h4);
    rd_reg(32'h100, 32'h0);

    // 4: command priority and program FSM
    wr_reg(32'h004, 32'h5);
    check("t4_abort_only", 32'({run_program, end_program, abort_program}), 32'h1);
    check("t4_active_after_abort", 32'(active_program), 32'h0);
    idle(1);
    check("t4_pulse_one_cycle", 32'({run_program, end_program, abort_program}), 32'h0);
    check("t4_still_idle", 32'(active_program), 32'h0);
    rd_reg(32'h004, 32'h0);
    rd_reg(32'h100, 32'h8);
    wr_reg(32'h100, 32'h8);
    wr_reg(32'h004, 32'h1);
    check("t4_run_pulse", 32'({run_program, end_program, abort_program}), 32'h4);
    idle(1);
    check("t4_active", 32'(active_program), 32'h1);
    rd_reg(32'h100, 32'h1);
    wr_reg(32'h004, 32'h2);
    check("t4_end_pulse", 32'({run_program, end_program, abort_program}), 32'h2);
    idle(1);
    check("t4_inactive", 32'(active_program), 32'h0);
    rd_reg(32'h100, 32'h8);
    wr_reg(32'h100, 32'h8);

    // 5: monitor banks and counter registers
    rd_reg(AMB + 32'd4 * (NUM_MON - 1), 32'h0000_A00F);
    check("t5_valid_next_cycle", 32'(bus.slave_rd_valid), 32'h1);
    idle(1);
    check("t5_valid_one_cycle", 32'(bus.slave_rd_valid), 32'h0);
    rd_reg(AMB + 32'd4 * NUM_MON, 32'h0);
    rd_reg(VMB + 32'd12, 32'h0000_B003);
    rd_reg(VMB + 32'd4 * NUM_MON, 32'h0);
    rd_reg(AMB + 32'd2, 32'h0);
    rd_reg(32'h104, 32'h1234);
    rd_reg(32'h108, 32'h0055);
    rd_reg(32'h10C, 32'h5678);
    rd_reg(32'h110, 32'h0066);
    rd_reg(32'h200, 32'h0);

    // Freeze stalls the burst and holds the word count
    wr_reg(32'h004, 32'h18);
    check("frz_levels", 32'({freeze_addr_fifo, freeze_vector_fifo}), 32'h3);
    rd_reg(32'h004, 32'h18);
    wr_reg(32'h004, 32'h0288);
    push_q.push_back(32'h3000); push_q.push_back(32'h3004);
    wr_reg(32'h000, 32'h3000);
    check("frz_no_wr", 32'(addr_fifo_wr), 32'h0);
    idle(2);
    rd_reg(32'h100, 32'h0202);
    wr_reg(32'h004, 32'h0280);
    check("frz_release_wr", 32'(addr_fifo_wr), 32'h1);
    idle(3);
    rd_reg(32'h100, 32'h0);

    // Abort flushes a pending burst in the abort cycle
    wr_reg(32'h004, 32'h0388);
    wr_reg(32'h000, 32'h7000);
    idle(1);
    wr_reg(32'h004, 32'h4);
    check("abort_pulse", 32'(abort_program), 32'h1);
    check("abort_gates_wr", 32'(addr_fifo_wr), 32'h0);
    idle(1);
    check("abort_flushed", 32'(addr_fifo_wr), 32'h0);
    rd_reg(32'h100, 32'h8);
    wr_reg(32'h100, 32'h8);

    // Count 0 sends one word; stride wraps at 32 bits
    wr_reg(32'h004, 32'h0080);
    push_q.push_back(32'h8000);
    wr_reg(32'h000, 32'h8000);
    idle(2);
    wr_reg(32'h004, 32'h0280);
    push_q.push_back(32'hFFFF_FFFC); push_q.push_back(32'h0);
    wr_reg(32'h000, 32'hFFFF_FFFC);
    idle(3);
    rd_reg(32'h100, 32'h0);

    // Interrupt: enable both sources, end sets prog_done
    wr_reg(32'h008, 32'h3);
    rd_reg(32'h008, {30'b0, IRQ_ON, IRQ_ON});
    wr_reg(32'h004, 32'h1);
    wr_reg(32'h004, 32'h2);
    idle(2);
    check("irq_on_done", 32'(irq), 32'(IRQ_ON));
    wr_reg(32'h100, 32'h8);
    idle(1);
    check("irq_cleared", 32'(irq), 32'h0);

    // 6: async reset in the middle of a burst
    wr_reg(32'h004, 32'h1);
    wr_reg(32'h004, 32'h0490);
    push_q.push_back(32'h4000);
    wr_reg(32'h000, 32'h4000);
    check("t6_active_before", 32'(active_program), 32'h1);
    #6;
    reset = 1'b0;
    #1;
    check("t6_async_outputs", 32'(out_vec()), 32'h0);
    check("t6_async_din", addr_fifo_din, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    idle(1);
    rd_reg(32'h100, 32'h0);
    rd_reg(32'h004, 32'h0);
    idle(3);

    check("push_queue_drained", 32'(push_q.size()), 32'h0);
    check("read_queue_drained", 32'(rd_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
